// File: rtl/ysyx_25050148_csr_unit.sv
// Machine-mode CSR file with csrrw/rs/rc, trap entry/mret sequencing and redirect PC.
// Define CSR_MCYCLE_EN to add the 64-bit mcycle counter at 0xB00 (and 0xB80 when XLEN=32).
module ysyx_25050148_csr_unit #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] MVENDORID   = 32'h7973_7978,
  parameter logic [31:0] MARCHID     = 32'h017E_3C24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_valid,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  // csr_en, trap_valid and mret_valid are single-cycle qualifiers with no back-pressure:
  // each takes effect at the clk edge that closes the cycle in which it is high.

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
`ifdef CSR_MCYCLE_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
`endif

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
`ifdef CSR_MCYCLE_EN
  logic [63:0]     mcycle;
`endif

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] misa_rd;
  logic [XLEN-1:0] cur_val;
  logic [XLEN-1:0] new_val;
  logic            addr_ok;
  logic            wr_attempt;
  logic            wr_en;

  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie;
    mstatus_rd[3]     = mie;
  end

  // MXL in the top two bits (1 for RV32, 2 for RV64), I extension at bit 8.
  always_comb begin
    misa_rd                   = '0;
    misa_rd[XLEN-1:XLEN-2]    = (XLEN == 64) ? 2'b10 : 2'b01;
    misa_rd[8]                = 1'b1;
  end

  always_comb begin
    addr_ok = 1'b1;
    cur_val = '0;
    case (csr_addr)
      A_MSTATUS:   cur_val = mstatus_rd;
      A_MISA:      cur_val = misa_rd;
      A_MTVEC:     cur_val = mtvec;
      A_MSCRATCH:  cur_val = mscratch;
      A_MEPC:      cur_val = mepc;
      A_MCAUSE:    cur_val = mcause;
      A_MVENDORID: cur_val = XLEN'(MVENDORID);
      A_MARCHID:   cur_val = XLEN'(MARCHID);
`ifdef CSR_MCYCLE_EN
      A_MCYCLE:    cur_val = mcycle[XLEN-1:0];
      A_MCYCLEH: begin
        if (XLEN == 32) cur_val = XLEN'(mcycle[63:32]);
        else            addr_ok = 1'b0;
      end
`endif
      default:     addr_ok = 1'b0;
    endcase
  end

  // Set/clear with a zero mask is a pure read, so it may target read-only registers.
  always_comb begin
    wr_attempt  = csr_en && ((csr_op == OP_RW) ||
                  (((csr_op == OP_RS) || (csr_op == OP_RC)) && (csr_wdata != '0)));
    csr_illegal = csr_en && (!addr_ok || (wr_attempt && (csr_addr[11:10] == 2'b11)));
    wr_en       = wr_attempt && !csr_illegal;
    csr_rdata   = csr_illegal ? '0 : cur_val;
  end

  always_comb begin
    case (csr_op)
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = cur_val | csr_wdata;
      OP_RC:   new_val = cur_val & ~csr_wdata;
      default: new_val = cur_val;
    endcase
  end

  always_comb begin
    redirect_valid = trap_valid | mret_valid;
    if (trap_valid)      redirect_pc = mtvec;
    else if (mret_valid) redirect_pc = mepc;
    else                 redirect_pc = '0;
  end

  // Trap and mret own the registers they touch; a concurrent CSR write to those is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie      <= MSTATUS_RST[3];
      mpie     <= MSTATUS_RST[7];
      mtvec    <= XLEN'(MTVEC_RST) & ALIGN_MASK;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      if (trap_valid) begin
        mepc   <= trap_pc & ALIGN_MASK;
        mcause <= trap_cause;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (mret_valid) begin
        mie    <= mpie;
        mpie   <= 1'b1;
      end
      if (wr_en) begin
        case (csr_addr)
          A_MSTATUS: begin
            if (!trap_valid && !mret_valid) begin
              mie  <= new_val[3];
              mpie <= new_val[7];
            end
          end
          A_MTVEC:    mtvec    <= new_val & ALIGN_MASK;
          A_MSCRATCH: mscratch <= new_val;
          A_MEPC:     if (!trap_valid) mepc   <= new_val & ALIGN_MASK;
          A_MCAUSE:   if (!trap_valid) mcause <= new_val;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_MCYCLE_EN
  logic [63:0] lo_written;
  logic [63:0] hi_written;

  always_comb begin
    lo_written               = mcycle;
    lo_written[XLEN-1:0]     = new_val;
    hi_written               = mcycle;
    hi_written[63:32]        = new_val[31:0];
  end

  // A written half replaces the count for that cycle; counting resumes on the next edge.
  always_ff @(posedge clk) begin
    if (rst)                                          mcycle <= '0;
    else if (wr_en && (csr_addr == A_MCYCLE))         mcycle <= lo_written;
    else if (wr_en && (csr_addr == A_MCYCLEH))        mcycle <= hi_written;
    else                                              mcycle <= mcycle + 64'd1;
  end
`endif

endmodule
